mem_stage_rx: RTL and testbench



---
 rtl/mem_stage_rx.sv | 143 ++++++++++++++
 tb/tb_mem_stage_rx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_rx.sv
// Memory-access pipeline stage: waits for load responses, extends/aligns load data,
// buffers one response across write-back stalls and drops responses orphaned by a flush.
//
// state  | meaning
// IDLE   | no load response outstanding
// WAIT   | load in stage, response not yet returned
// HOLD   | response captured in buf_r, write-back stalled
// CANCEL | flushed load still has a response in flight; discard it
module mem_stage_rx #(
    parameter int PT_WD = 82
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                es_to_ms_valid,
    input  logic [PT_WD+75:0]   es_to_ms_bus,
    output logic                ms_allowin,
    output logic                ms_to_ws_valid,
    output logic [PT_WD+69:0]   ms_to_ws_bus,
    input  logic                ws_allowin,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                ws_flush_pipe,
    output logic [38:0]         ms_to_ds_bus
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, CANCEL} st_t;

    st_t                st;
    logic               ms_valid;
    logic [PT_WD+75:0]  bus_r;
    logic [31:0]        buf_r;

    logic [PT_WD-1:0]   pt;
    logic               mem_req;
    logic [2:0]         ld_op;
    logic [1:0]         addr_lo;
    logic               gr_we;
    logic [4:0]         dest;
    logic [31:0]        alu_result;
    logic [31:0]        pc;

    logic               ms_ready_go;
    logic               accept;
    logic               acc_load;
    logic [31:0]        ld_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_ext;
    logic [31:0]        final_result;
    logic               fwd_we;
    logic               fwd_busy;

    assign {pt, mem_req, ld_op, addr_lo, gr_we, dest, alu_result, pc} = bus_r;

    assign ms_ready_go = !mem_req || (st == WAIT && data_sram_data_ok) || st == HOLD;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
    assign accept      = es_to_ms_valid && ms_allowin && !ws_flush_pipe;
    assign acc_load    = accept && es_to_ms_bus[75];

    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush_pipe;

    always_comb begin
        ld_data = (st == HOLD) ? buf_r : data_sram_rdata;
        case (addr_lo)
            2'd0:    ld_byte = ld_data[7:0];
            2'd1:    ld_byte = ld_data[15:8];
            2'd2:    ld_byte = ld_data[23:16];
            default: ld_byte = ld_data[31:24];
        endcase
        ld_half = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
        case (ld_op)
            3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b011:  ld_ext = {24'd0, ld_byte};
            3'b100:  ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_data;
        endcase
        final_result = mem_req ? ld_ext : alu_result;
    end

    assign fwd_we       = ms_valid && gr_we;
    assign fwd_busy     = fwd_we && mem_req && !ms_ready_go;
    assign ms_to_ds_bus = {fwd_we, fwd_busy, dest, final_result};
    assign ms_to_ws_bus = {pt, gr_we, dest, final_result, pc};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
            buf_r    <= 32'd0;
            st       <= IDLE;
        end else begin
            if (ws_flush_pipe)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;

            if (accept)
                bus_r <= es_to_ms_bus;

            case (st)
                IDLE: begin
                    // A response racing its own load into the stage is parked until it arrives.
                    if (data_sram_data_ok && acc_load) begin
                        st    <= HOLD;
                        buf_r <= data_sram_rdata;
                    end else if (acc_load) begin
                        st <= WAIT;
                    end
                end
                WAIT: begin
                    if (ws_flush_pipe) begin
                        st <= data_sram_data_ok ? IDLE : CANCEL;
                    end else if (data_sram_data_ok) begin
                        if (ws_allowin) begin
                            st <= acc_load ? WAIT : IDLE;
                        end else begin
                            st    <= HOLD;
                            buf_r <= data_sram_rdata;
                        end
                    end
                end
                HOLD: begin
                    if (ws_flush_pipe)
                        st <= IDLE;
                    else if (ws_allowin)
                        st <= acc_load ? WAIT : IDLE;
                end
                default: begin
                    // Stale response consumed; a load accepted meanwhile now starts waiting.
                    if (data_sram_data_ok)
                        st <= (acc_load || (ms_valid && mem_req && !ws_flush_pipe)) ? WAIT : IDLE;
                end
            endcase
        end
    end

    a_no_spurious_data_ok: assert property (
        @(posedge clk) disable iff (!resetn)
        (data_sram_data_ok && st == IDLE) |-> acc_load
    );

endmodule

// File: tb/tb_mem_stage_rx.sv
// Directed bench for mem_stage_rx; expected write-back results are queued at issue
// and a negedge monitor compares them against each accepted output.
`timescale 1ns/1ps
module tb_mem_stage_rx;

    localparam int PT_WD = 82;

    logic                clk;
    logic                resetn;
    logic                es_to_ms_valid;
    logic [PT_WD+75:0]   es_to_ms_bus;
    logic                ms_allowin;
    logic                ms_to_ws_valid;
    logic [PT_WD+69:0]   ms_to_ws_bus;
    logic                ws_allowin;
    logic                data_sram_data_ok;
    logic [31:0]         data_sram_rdata;
    logic                ws_flush_pipe;
    logic [38:0]         ms_to_ds_bus;

    int n_checks = 0;
    int n_pass   = 0;
    logic [PT_WD+69:0] sb_q[$];
    logic [PT_WD+69:0] mon_exp;

    mem_stage_rx #(.PT_WD(PT_WD)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ws_allowin        (ws_allowin),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_flush_pipe     (ws_flush_pipe),
        .ms_to_ds_bus      (ms_to_ds_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PT_WD+69:0] act, input logic [PT_WD+69:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic issue(input logic mreq, input logic [2:0] op, input logic [1:0] alo,
                         input logic we, input logic [4:0] dst, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] exp_res, input bit push);
        logic [PT_WD-1:0] pt;
        pt = {pc[17:0], alu, pc};
        es_to_ms_bus   = {pt, mreq, op, alo, we, dst, alu, pc};
        es_to_ms_valid = 1'b1;
        if (push)
            sb_q.push_back({pt, we, dst, exp_res, pc});
    endtask

    // One load whose response returns in the first cycle after acceptance.
    task automatic load1(input string name, input logic [2:0] op, input logic [1:0] alo,
                         input logic [31:0] rdata, input logic [31:0] exp_res, input logic [31:0] pc);
        issue(1'b1, op, alo, 1'b1, 5'd3, 32'h0000_0100 | 32'(alo), pc, exp_res, 1'b1);
        cyc();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rdata;
        samp();
        chk({name, "_valid"}, ms_to_ws_valid, 1'b1);
        chk({name, "_fwd_data"}, ms_to_ds_bus[31:0], exp_res);
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
    endtask

    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %h expected none", ms_to_ws_bus);
            end else begin
                mon_exp = sb_q.pop_front();
                chk("ws_bus", ms_to_ws_bus, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        ws_flush_pipe     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        samp();
        chk("rst_valid", ms_to_ws_valid, 1'b0);
        chk("rst_allowin", ms_allowin, 1'b1);
        chk("rst_ds_bus", ms_to_ds_bus, 39'd0);
        cyc();
        resetn = 1'b1;
        cyc();

        // non-load, one-cycle latency
        issue(1'b0, 3'd0, 2'd0, 1'b1, 5'd5, 32'h1234_5678, 32'h1c00_0000, 32'h1234_5678, 1'b1);
        samp();
        chk("nl_allowin", ms_allowin, 1'b1);
        cyc();
        es_to_ms_valid = 1'b0;
        samp();
        chk("nl_valid", ms_to_ws_valid, 1'b1);
        chk("nl_fwd", ms_to_ds_bus, {1'b1, 1'b0, 5'd5, 32'h1234_5678});
        cyc();

        // back-to-back non-loads, then a write-back stall
        issue(1'b0, 3'd0, 2'd0, 1'b1, 5'd6, 32'hA5A5_0001, 32'h1c00_0004, 32'hA5A5_0001, 1'b1);
        cyc();
        issue(1'b0, 3'd0, 2'd0, 1'b0, 5'd7, 32'h5A5A_0002, 32'h1c00_0008, 32'h5A5A_0002, 1'b1);
        cyc();
        es_to_ms_valid = 1'b0;
        ws_allowin     = 1'b0;
        samp();
        chk("stall_allowin", ms_allowin, 1'b0);
        chk("stall_fwd_we", ms_to_ds_bus[38], 1'b0);
        cyc();
        ws_allowin = 1'b1;
        cyc();

        // load extension / alignment
        load1("ld_b_3",  3'b001, 2'd3, 32'h80AA_BBCC, 32'hFFFF_FF80, 32'h1c00_0010);
        load1("ld_hu_2", 3'b100, 2'd2, 32'h80AA_BBCC, 32'h0000_80AA, 32'h1c00_0014);
        load1("ld_h_0",  3'b010, 2'd0, 32'h80AA_BBCC, 32'hFFFF_BBCC, 32'h1c00_0018);
        load1("ld_bu_1", 3'b011, 2'd1, 32'h80AA_BBCC, 32'h0000_00BB, 32'h1c00_001c);
        load1("ld_x_7",  3'b111, 2'd2, 32'h80AA_BBCC, 32'h80AA_BBCC, 32'h1c00_0020);

        // load waiting three cycles for its response
        issue(1'b1, 3'b000, 2'd0, 1'b1, 5'd7, 32'h0000_0200, 32'h1c00_0024, 32'hCAFE_F00D, 1'b1);
        cyc();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("wait_busy", ms_to_ds_bus[37], 1'b1);
            chk("wait_allowin", ms_allowin, 1'b0);
            chk("wait_valid", ms_to_ws_valid, 1'b0);
            cyc();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_F00D;
        samp();
        chk("wait_done_valid", ms_to_ws_valid, 1'b1);
        chk("wait_done_busy", ms_to_ds_bus[37], 1'b0);
        cyc();
        data_sram_data_ok = 1'b0;

        // write-back stall holds the response while rdata moves on
        issue(1'b1, 3'b000, 2'd0, 1'b1, 5'd8, 32'h0000_0300, 32'h1c00_0028, 32'hDEAD_BEEF, 1'b1);
        cyc();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        samp();
        chk("hold_valid0", ms_to_ws_valid, 1'b1);
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h5555_5555;
        samp();
        chk("hold_valid1", ms_to_ws_valid, 1'b1);
        chk("hold_data", ms_to_ds_bus[31:0], 32'hDEAD_BEEF);
        cyc();
        ws_allowin = 1'b1;
        cyc();
        samp();
        chk("hold_gone", ms_to_ws_valid, 1'b0);
        cyc();

        // flush in WAIT; stale response must not satisfy the next load
        issue(1'b1, 3'b000, 2'd0, 1'b1, 5'd9, 32'h0000_0400, 32'h1c00_002c, 32'h0, 1'b0);
        cyc();
        es_to_ms_valid = 1'b0;
        ws_flush_pipe  = 1'b1;
        samp();
        chk("cxl_flush_valid", ms_to_ws_valid, 1'b0);
        cyc();
        ws_flush_pipe = 1'b0;
        issue(1'b1, 3'b000, 2'd0, 1'b1, 5'd10, 32'h0000_0500, 32'h1c00_0030, 32'h2222_2222, 1'b1);
        samp();
        chk("cxl_allowin", ms_allowin, 1'b1);
        cyc();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_1111;
        samp();
        chk("cxl_stale_valid", ms_to_ws_valid, 1'b0);
        chk("cxl_stale_busy", ms_to_ds_bus[37], 1'b1);
        cyc();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        samp();
        chk("cxl_gap_valid", ms_to_ws_valid, 1'b0);
        cyc();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h2222_2222;
        samp();
        chk("cxl_real_valid", ms_to_ws_valid, 1'b1);
        cyc();
        data_sram_data_ok = 1'b0;

        // flush and response in the same cycle: consumed, no cancel pending
        issue(1'b1, 3'b000, 2'd0, 1'b1, 5'd11, 32'h0000_0600, 32'h1c00_0034, 32'h0, 1'b0);
        cyc();
        es_to_ms_valid    = 1'b0;
        ws_flush_pipe     = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h3333_3333;
        samp();
        chk("fdo_valid", ms_to_ws_valid, 1'b0);
        cyc();
        ws_flush_pipe     = 1'b0;
        data_sram_data_ok = 1'b0;
        issue(1'b1, 3'b000, 2'd0, 1'b1, 5'd12, 32'h0000_0700, 32'h1c00_0038, 32'h4444_4444, 1'b1);
        samp();
        chk("fdo_allowin", ms_allowin, 1'b1);
        cyc();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h4444_4444;
        samp();
        chk("fdo_next_valid", ms_to_ws_valid, 1'b1);
        cyc();
        data_sram_data_ok = 1'b0;

        repeat (3) cyc();
        chk("sb_empty", 152'(sb_q.size()), 152'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
